reg_bank_arbiter: RTL and testbench
===================================

// Module: reg_bank_arbiter
// PURPOSE
//  Shares the single-port register_bank between two requesters: port 0 (cmd_dispatcher, UART command path)
//  and port 1 (secondary/debug master). Round-robin arbitration with a req/gnt handshake. One transaction
//  in flight at a time. Read data returns with a fixed, parameterised latency. Sits between the requesters
//  and register_bank inside the command/response tile.
// PARAMETERS
//  ADDR_W    8  register address width
//  DATA_W    8  register data width
//  READ_LAT  1  bank cycles from read_strobe to valid read_data (>=1)
// PORTS
//  clk             in   1       system clock
//  rst             in   1       asynchronous reset, active-high
//  r0_req/r1_req   in   1       request; hold with fields stable until gnt
//  r0_we/r1_we     in   1       1=write, 0=read
//  r0_addr/r1_addr in   ADDR_W  register address
//  r0_wdata/r1_wdata in DATA_W  write data
//  r0_gnt/r1_gnt   out  1       1-cycle pulse: request accepted and issued to bank
//  r0_rvalid/r1_rvalid out 1    1-cycle pulse: read data valid on rN_rdata
//  r0_rdata/r1_rdata out DATA_W read data, held until next read completes for that port
//  mem_addr        out  ADDR_W  to register_bank addr
//  mem_write_en    out  1       to register_bank write_en (1-cycle pulse)
//  mem_write_data  out  DATA_W  to register_bank write_data
//  mem_read_en     out  1       to register_bank read_strobe (1-cycle pulse)
//  mem_read_data   in   DATA_W  from register_bank read_data
// BEHAVIOUR
//  - Reset: state=IDLE; all outputs (gnt, rvalid, rdata, mem_*) = 0; last_served=1 (port 0 wins first).
//  - All outputs registered. FSM: IDLE -> ISSUE -> (write) IDLE | (read) WAIT -> RESP -> IDLE.
//  - IDLE, cycle N: if any req, pick winner, latch we/addr/wdata/id, go ISSUE. Only r0 -> 0; only r1 -> 1;
//    both -> port != last_served; update last_served to winner.
//  - ISSUE, cycle N+1: mem_addr=latched addr; mem_write_en=we, mem_read_en=!we, 1 cycle; winner gnt=1,
//    1 cycle. Write -> IDLE. Read -> WAIT with lat_cnt=READ_LAT-1.
//  - WAIT: decrement lat_cnt. When lat_cnt==0, capture mem_read_data into winner's rdata
//    (edge ending cycle N+1+READ_LAT), go RESP.
//  - RESP, cycle N+2+READ_LAT: winner rvalid=1 for 1 cycle; go IDLE. Loser's rdata/rvalid untouched.
//  - Latency: write gnt at N+1; read rvalid at N+2+READ_LAT (N+3 for default).
//  - Back-to-back: a req still high in the IDLE cycle after gnt/RESP is a new transaction.
//    Min spacing: write 2 cycles, read READ_LAT+3 cycles.
//  - Fairness under contention: strict alternation 0,1,0,1... Idle port never blocks the other.
//  - Latched transaction completes even if req drops or fields change after IDLE sampling.
//    Dropping req before gnt is a requester protocol violation; arbiter does not detect it.
//  - mem_addr/mem_write_data hold last issued values outside ISSUE. Enables are the only qualifiers.
//  - Never more than one of mem_write_en/mem_read_en high. Never both gnt or both rvalid high.
//  - Reset mid-operation (any state): immediate return to reset values. No gnt/rvalid/mem pulse is produced
//    for the aborted transaction. Arbitration restarts with port 0 priority.
// TESTING
//  1 r0 write addr=0x05 data=0xA5 -> mem_write_en + r0_gnt at N+1, addr 0x05/0xA5. Read back via r0 -> r0_rdata=0xA5 at N+3.
//  2 r1 read addr=0x05 alone -> mem_read_en at N+1, r1_rvalid at N+3 with 0xA5. r0_rdata/r0_rvalid unchanged.
//  3 r0,r1 both req continuously, 4 txns each -> gnt order 0,1,0,1,... No port starves; no double enable.
//  4 r0 back-to-back writes 0x10..0x13, r1 idle -> r0_gnt every 2 cycles. Bank holds all 4 values.
//  5 rst asserted in WAIT of r1 read -> outputs 0 immediately, no r1_rvalid. Next contended req goes to port 0.
//  6 READ_LAT=3 build, r0 read -> mem_read_en at N+1, r0_rvalid at N+5 with correct data.

Source files
------------

// File: rtl/reg_bank_arbiter.sv
// reg_bank_arbiter: shares the single-port register_bank between two requesters.
// Round-robin arbitration with a req/gnt handshake and one transaction in flight.
// Read data returns READ_LAT bank cycles after the read strobe.
//
// Ports:
//   clk, rst                       clock, asynchronous active-high reset
//   rN_req/rN_we/rN_addr/rN_wdata  requester N command (held stable until rN_gnt)
//   rN_gnt                         1-cycle pulse: request issued to the bank
//   rN_rvalid/rN_rdata             1-cycle read-valid pulse; rdata held until next read
//   mem_addr/mem_write_data        bank address/data, hold last issued values
//   mem_write_en/mem_read_en       1-cycle bank strobes
//   mem_read_data                  bank read data
module reg_bank_arbiter #(
    parameter int unsigned ADDR_W   = 8,
    parameter int unsigned DATA_W   = 8,
    parameter int unsigned READ_LAT = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              r0_req,
    input  logic              r0_we,
    input  logic [ADDR_W-1:0] r0_addr,
    input  logic [DATA_W-1:0] r0_wdata,
    input  logic              r1_req,
    input  logic              r1_we,
    input  logic [ADDR_W-1:0] r1_addr,
    input  logic [DATA_W-1:0] r1_wdata,
    output logic              r0_gnt,
    output logic              r1_gnt,
    output logic              r0_rvalid,
    output logic              r1_rvalid,
    output logic [DATA_W-1:0] r0_rdata,
    output logic [DATA_W-1:0] r1_rdata,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_write_en,
    output logic [DATA_W-1:0] mem_write_data,
    output logic              mem_read_en,
    input  logic [DATA_W-1:0] mem_read_data
);

    localparam int unsigned CNT_W = (READ_LAT > 1) ? $clog2(READ_LAT) : 1;
    localparam logic [CNT_W-1:0] LAT_LOAD = CNT_W'(READ_LAT - 1);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ISSUE,
        ST_WAIT,
        ST_RESP
    } state_t;

    state_t            state_q, state_d;
    logic              last_served_q, last_served_d;
    logic              we_q, we_d;
    logic              id_q, id_d;
    logic [CNT_W-1:0]  lat_cnt_q, lat_cnt_d;
    logic              winner;

    logic              r0_gnt_d, r1_gnt_d;
    logic              r0_rvalid_d, r1_rvalid_d;
    logic [DATA_W-1:0] r0_rdata_d, r1_rdata_d;
    logic [ADDR_W-1:0] mem_addr_d;
    logic [DATA_W-1:0] mem_write_data_d;
    logic              mem_write_en_d, mem_read_en_d;

    // State and registered outputs
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q        <= ST_IDLE;
            last_served_q  <= 1'b1;
            we_q           <= 1'b0;
            id_q           <= 1'b0;
            lat_cnt_q      <= '0;
            r0_gnt         <= 1'b0;
            r1_gnt         <= 1'b0;
            r0_rvalid      <= 1'b0;
            r1_rvalid      <= 1'b0;
            r0_rdata       <= '0;
            r1_rdata       <= '0;
            mem_addr       <= '0;
            mem_write_data <= '0;
            mem_write_en   <= 1'b0;
            mem_read_en    <= 1'b0;
        end else begin
            state_q        <= state_d;
            last_served_q  <= last_served_d;
            we_q           <= we_d;
            id_q           <= id_d;
            lat_cnt_q      <= lat_cnt_d;
            r0_gnt         <= r0_gnt_d;
            r1_gnt         <= r1_gnt_d;
            r0_rvalid      <= r0_rvalid_d;
            r1_rvalid      <= r1_rvalid_d;
            r0_rdata       <= r0_rdata_d;
            r1_rdata       <= r1_rdata_d;
            mem_addr       <= mem_addr_d;
            mem_write_data <= mem_write_data_d;
            mem_write_en   <= mem_write_en_d;
            mem_read_en    <= mem_read_en_d;
        end
    end

    // Next state and next output values; pulses default low, held values default to current
    always_comb begin
        state_d          = state_q;
        last_served_d    = last_served_q;
        we_d             = we_q;
        id_d             = id_q;
        lat_cnt_d        = lat_cnt_q;
        winner           = 1'b0;
        r0_gnt_d         = 1'b0;
        r1_gnt_d         = 1'b0;
        r0_rvalid_d      = 1'b0;
        r1_rvalid_d      = 1'b0;
        r0_rdata_d       = r0_rdata;
        r1_rdata_d       = r1_rdata;
        mem_addr_d       = mem_addr;
        mem_write_data_d = mem_write_data;
        mem_write_en_d   = 1'b0;
        mem_read_en_d    = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (r0_req || r1_req) begin
                    // Under contention the port not served last time wins
                    winner           = (r0_req && r1_req) ? ~last_served_q : r1_req;
                    last_served_d    = winner;
                    id_d             = winner;
                    we_d             = winner ? r1_we : r0_we;
                    mem_addr_d       = winner ? r1_addr : r0_addr;
                    mem_write_data_d = winner ? r1_wdata : r0_wdata;
                    mem_write_en_d   = we_d;
                    mem_read_en_d    = ~we_d;
                    r0_gnt_d         = ~winner;
                    r1_gnt_d         = winner;
                    state_d          = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                if (we_q) begin
                    state_d = ST_IDLE;
                end else begin
                    lat_cnt_d = LAT_LOAD;
                    state_d   = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (lat_cnt_q == '0) begin
                    // Bank data is valid this cycle; capture and flag it next cycle
                    if (id_q) begin
                        r1_rdata_d  = mem_read_data;
                        r1_rvalid_d = 1'b1;
                    end else begin
                        r0_rdata_d  = mem_read_data;
                        r0_rvalid_d = 1'b1;
                    end
                    state_d = ST_RESP;
                end else begin
                    lat_cnt_d = lat_cnt_q - CNT_W'(1);
                end
            end
            ST_RESP: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_reg_bank_arbiter.sv
// tb_reg_bank_arbiter: self-checking bench for reg_bank_arbiter.
// Main instance uses READ_LAT=1 with a transaction-level reference model;
// a second instance with READ_LAT=3 checks the longer read latency.
module tb_reg_bank_arbiter;

    localparam int unsigned LAT = 1;

    logic       clk = 1'b0;
    logic       rst;
    logic       r0_req, r0_we, r1_req, r1_we;
    logic [7:0] r0_addr, r0_wdata, r1_addr, r1_wdata;
    logic       r0_gnt, r1_gnt, r0_rvalid, r1_rvalid;
    logic [7:0] r0_rdata, r1_rdata;
    logic [7:0] mem_addr, mem_write_data, mem_read_data;
    logic       mem_write_en, mem_read_en;

    logic       s_req, s_we;
    logic [7:0] s_addr, s_wdata;
    logic       t_gnt0, t_gnt1, t_rv0, t_rv1, t_wen, t_ren;
    logic [7:0] t_rd0, t_rd1, t_addr, t_wdata, t_rdata;

    always #5 clk = ~clk;

    reg_bank_arbiter #(.ADDR_W(8), .DATA_W(8), .READ_LAT(LAT)) dut (
        .clk(clk), .rst(rst),
        .r0_req(r0_req), .r0_we(r0_we), .r0_addr(r0_addr), .r0_wdata(r0_wdata),
        .r1_req(r1_req), .r1_we(r1_we), .r1_addr(r1_addr), .r1_wdata(r1_wdata),
        .r0_gnt(r0_gnt), .r1_gnt(r1_gnt), .r0_rvalid(r0_rvalid), .r1_rvalid(r1_rvalid),
        .r0_rdata(r0_rdata), .r1_rdata(r1_rdata),
        .mem_addr(mem_addr), .mem_write_en(mem_write_en), .mem_write_data(mem_write_data),
        .mem_read_en(mem_read_en), .mem_read_data(mem_read_data)
    );

    reg_bank_arbiter #(.ADDR_W(8), .DATA_W(8), .READ_LAT(3)) dut3 (
        .clk(clk), .rst(rst),
        .r0_req(s_req), .r0_we(s_we), .r0_addr(s_addr), .r0_wdata(s_wdata),
        .r1_req(1'b0), .r1_we(1'b0), .r1_addr(8'h00), .r1_wdata(8'h00),
        .r0_gnt(t_gnt0), .r1_gnt(t_gnt1), .r0_rvalid(t_rv0), .r1_rvalid(t_rv1),
        .r0_rdata(t_rd0), .r1_rdata(t_rd1),
        .mem_addr(t_addr), .mem_write_en(t_wen), .mem_write_data(t_wdata),
        .mem_read_en(t_ren), .mem_read_data(t_rdata)
    );

    // Register banks: 1-cycle read for dut, 3-stage read pipeline for dut3
    logic [7:0] bank  [256] = '{default: 8'h00};
    logic [7:0] bank3 [256] = '{default: 8'h00};
    logic [7:0] pipe3 [3];

    always @(posedge clk) begin
        if (mem_write_en) bank[mem_addr] <= mem_write_data;
        if (mem_read_en)  mem_read_data  <= bank[mem_addr];
    end

    always @(posedge clk) begin
        if (t_wen) bank3[t_addr] <= t_wdata;
        if (t_ren) pipe3[0] <= bank3[t_addr];
        pipe3[1] <= pipe3[0];
        pipe3[2] <= pipe3[1];
    end
    assign t_rdata = pipe3[2];

    // Reference model state
    typedef struct {
        logic       we;
        logic [7:0] addr;
        logic [7:0] wdata;
        int         gap;
    } txn_t;

    txn_t       q0[$], q1[$];
    logic [7:0] model_mem [256] = '{default: 8'h00};
    int         cyc, total, bad;
    int         gnt_at, rv_at, free_at, last_win, wait0, wait1, gnt_port, rv_port;
    logic       gnt_we;
    logic [7:0] gnt_addr, gnt_wdata, rv_data, exp_maddr;
    logic [7:0] exp_rd [2];
    int         gnt_log[$];
    int         gnt0_cyc[$];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic model_reset();
        gnt_at    = -1;
        rv_at     = -1;
        free_at   = cyc;
        last_win  = 1;
        wait0     = 0;
        wait1     = 0;
        exp_rd[0] = 8'h00;
        exp_rd[1] = 8'h00;
        exp_maddr = 8'h00;
        q0.delete();
        q1.delete();
    endtask

    task automatic push(input int p, input logic we, input logic [7:0] addr,
                        input logic [7:0] wdata, input int gap);
        txn_t t;
        t.we = we; t.addr = addr; t.wdata = wdata; t.gap = gap;
        if (p == 0) begin
            if (q0.size() == 0) wait0 = gap;
            q0.push_back(t);
        end else begin
            if (q1.size() == 0) wait1 = gap;
            q1.push_back(t);
        end
    endtask

    task automatic drive(input logic p0, input logic p1);
        r0_req = p0; r0_we = 1'b0; r0_addr = 8'h00; r0_wdata = 8'h00;
        r1_req = p1; r1_we = 1'b0; r1_addr = 8'h00; r1_wdata = 8'h00;
        if (p0) begin
            r0_we = q0[0].we; r0_addr = q0[0].addr; r0_wdata = q0[0].wdata;
        end
        if (p1) begin
            r1_we = q1[0].we; r1_addr = q1[0].addr; r1_wdata = q1[0].wdata;
        end
    endtask

    // One clock: check this cycle's outputs, advance requesters, predict arbitration
    task automatic step();
        logic p0, p1;
        int   w;
        txn_t t;
        tick();
        if (gnt_at == cyc) exp_maddr = gnt_addr;
        if (rv_at == cyc)  exp_rd[rv_port] = rv_data;
        chk("r0_gnt", 32'(r0_gnt), 32'(gnt_at == cyc && gnt_port == 0));
        chk("r1_gnt", 32'(r1_gnt), 32'(gnt_at == cyc && gnt_port == 1));
        chk("mem_write_en", 32'(mem_write_en), 32'(gnt_at == cyc && gnt_we));
        chk("mem_read_en", 32'(mem_read_en), 32'(gnt_at == cyc && !gnt_we));
        chk("mem_addr", 32'(mem_addr), 32'(exp_maddr));
        if (gnt_at == cyc && gnt_we) chk("mem_write_data", 32'(mem_write_data), 32'(gnt_wdata));
        chk("r0_rvalid", 32'(r0_rvalid), 32'(rv_at == cyc && rv_port == 0));
        chk("r1_rvalid", 32'(r1_rvalid), 32'(rv_at == cyc && rv_port == 1));
        chk("r0_rdata", 32'(r0_rdata), 32'(exp_rd[0]));
        chk("r1_rdata", 32'(r1_rdata), 32'(exp_rd[1]));
        if (r0_gnt) begin
            gnt_log.push_back(0);
            gnt0_cyc.push_back(cyc);
        end
        if (r1_gnt) gnt_log.push_back(1);

        if (gnt_at == cyc && gnt_port == 0) begin
            void'(q0.pop_front());
            wait0 = (q0.size() != 0) ? q0[0].gap : 0;
        end else if (wait0 > 0) begin
            wait0--;
        end
        if (gnt_at == cyc && gnt_port == 1) begin
            void'(q1.pop_front());
            wait1 = (q1.size() != 0) ? q1[0].gap : 0;
        end else if (wait1 > 0) begin
            wait1--;
        end
        p0 = (q0.size() != 0) && (wait0 == 0);
        p1 = (q1.size() != 0) && (wait1 == 0);

        if (free_at <= cyc && (p0 || p1)) begin
            w        = (p0 && p1) ? (1 - last_win) : (p1 ? 1 : 0);
            last_win = w;
            t        = (w == 0) ? q0[0] : q1[0];
            gnt_at    = cyc + 1;
            gnt_port  = w;
            gnt_we    = t.we;
            gnt_addr  = t.addr;
            gnt_wdata = t.wdata;
            if (t.we) begin
                model_mem[t.addr] = t.wdata;
                free_at = cyc + 2;
            end else begin
                rv_at   = cyc + 2 + LAT;
                rv_port = w;
                rv_data = model_mem[t.addr];
                free_at = cyc + 3 + LAT;
            end
        end
        drive(p0, p1);
    endtask

    task automatic drain(input int limit);
        int   n;
        logic done;
        n = 0;
        while ((q0.size() != 0 || q1.size() != 0 || free_at > cyc) && n < limit) begin
            step();
            n++;
        end
        done = (q0.size() == 0) && (q1.size() == 0) && (free_at <= cyc);
        chk("drain_done", 32'(done), 32'(1));
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_gnt"}, 32'({r0_gnt, r1_gnt, t_gnt0, t_gnt1}), 32'(0));
        chk({tag, "_rvalid"}, 32'({r0_rvalid, r1_rvalid, t_rv0, t_rv1}), 32'(0));
        chk({tag, "_rdata"}, 32'({r0_rdata, r1_rdata, t_rd0, t_rd1}), 32'(0));
        chk({tag, "_mem_en"}, 32'({mem_write_en, mem_read_en, t_wen, t_ren}), 32'(0));
        chk({tag, "_mem_bus"}, 32'({mem_addr, mem_write_data, t_addr, t_wdata}), 32'(0));
    endtask

    initial begin
        total = 0; bad = 0; cyc = 0;
        rst = 1'b1;
        s_req = 1'b0; s_we = 1'b0; s_addr = 8'h00; s_wdata = 8'h00;
        model_reset();
        drive(1'b0, 1'b0);
        repeat (3) tick();
        chk_all_zero("reset");
        rst = 1'b0;
        model_reset();

        // Write 0xA5 to 0x05 via r0, then read it back via r0
        push(0, 1'b1, 8'h05, 8'hA5, 0);
        drain(20);
        chk("t1_bank", 32'(bank[8'h05]), 32'(8'hA5));
        push(0, 1'b0, 8'h05, 8'h00, 0);
        drain(20);
        chk("t1_r0_rdata", 32'(r0_rdata), 32'(8'hA5));

        // r1 reads 0x05 alone; r0 read data stays put
        push(1, 1'b0, 8'h05, 8'h00, 0);
        drain(20);
        chk("t2_r1_rdata", 32'(r1_rdata), 32'(8'hA5));
        chk("t2_r0_rdata", 32'(r0_rdata), 32'(8'hA5));

        // Back-to-back writes on r0 with r1 idle: one grant every 2 cycles
        gnt0_cyc.delete();
        for (int i = 0; i < 4; i++) push(0, 1'b1, 8'(8'h10 + i), 8'(8'h60 + i), 0);
        drain(40);
        chk("t4_gnt_count", 32'(gnt0_cyc.size()), 32'(4));
        if (gnt0_cyc.size() == 4)
            for (int i = 1; i < 4; i++)
                chk("t4_gnt_spacing", 32'(gnt0_cyc[i] - gnt0_cyc[i-1]), 32'(2));
        for (int i = 0; i < 4; i++)
            chk("t4_bank", 32'(bank[8'(8'h10 + i)]), 32'(8'h60 + i));

        // Reset while r1 read is waiting on the bank
        push(1, 1'b0, 8'h12, 8'h00, 0);
        step(); step(); step();
        rst = 1'b1;
        #1;
        chk_all_zero("t5_rst");
        tick();
        chk("t5_no_r1_rvalid", 32'(r1_rvalid), 32'(0));
        rst = 1'b0;
        model_reset();
        drive(1'b0, 1'b0);
        repeat (4) step();

        // Contention: strict alternation starting with port 0 after reset
        gnt_log.delete();
        for (int i = 0; i < 4; i++) begin
            push(0, 1'(i % 2), 8'(8'h20 + i), 8'(8'hC0 + i), 0);
            push(1, 1'(1 - i % 2), 8'(8'h20 + i), 8'(8'hD0 + i), 0);
        end
        drain(200);
        chk("t3_gnt_count", 32'(gnt_log.size()), 32'(8));
        if (gnt_log.size() == 8)
            for (int i = 0; i < 8; i++) chk("t3_gnt_order", 32'(gnt_log[i]), 32'(i % 2));

        // Random traffic on both ports over a small address window
        for (int i = 0; i < 60; i++) begin
            push(0, 1'($urandom_range(0, 1)), 8'($urandom_range(0, 15)), 8'($urandom),
                 int'($urandom_range(0, 3)));
            push(1, 1'($urandom_range(0, 1)), 8'($urandom_range(0, 15)), 8'($urandom),
                 int'($urandom_range(0, 3)));
        end
        drain(5000);

        // READ_LAT=3 instance: write 0x3C to 0x22, then read it back
        s_req = 1'b1; s_we = 1'b1; s_addr = 8'h22; s_wdata = 8'h3C;
        tick();
        chk("t6_wr_gnt", 32'({t_gnt0, t_wen, t_ren}), 32'(3'b110));
        s_req = 1'b0;
        tick();
        s_req = 1'b1; s_we = 1'b0; s_wdata = 8'h00;
        tick();
        chk("t6_rd_issue", 32'({t_gnt0, t_wen, t_ren}), 32'(3'b101));
        chk("t6_rd_addr", 32'(t_addr), 32'(8'h22));
        s_req = 1'b0;
        for (int k = 2; k <= 4; k++) begin
            tick();
            chk("t6_rvalid_early", 32'(t_rv0), 32'(0));
        end
        tick();
        chk("t6_rvalid", 32'(t_rv0), 32'(1));
        chk("t6_rdata", 32'(t_rd0), 32'(8'h3C));
        tick();
        chk("t6_rvalid_pulse", 32'(t_rv0), 32'(0));
        chk("t6_rdata_hold", 32'(t_rd0), 32'(8'h3C));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
